// File: rtl/alu_reservation_station_pkg.sv
// alu_reservation_station_pkg: shared widths, opcodes, entry/CDB types and the operand snoop helper
package alu_reservation_station_pkg;
  localparam int RS_SIZE = 16;
  localparam int RS_W = 4;
  localparam int ROB_W = 4;
  localparam logic [31:0] NULL32 = 32'd0;
  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;
  localparam logic [5:0] OP_AND = 6'd3;
  localparam logic [5:0] OP_OR = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5;
  localparam logic [5:0] OP_SLT = 6'd6;
  localparam logic [5:0] OP_BEQ = 6'd7;
  localparam logic [5:0] OP_BNE = 6'd8;
  localparam logic [5:0] OP_JAL = 6'd9;
  localparam logic [5:0] OP_JALR = 6'd10;
  typedef struct packed {
    logic busy;
    logic [5:0] op;
    logic [31:0] vj;
    logic [31:0] vk;
    logic qj_busy;
    logic [ROB_W-1:0] qj;
    logic qk_busy;
    logic [ROB_W-1:0] qk;
    logic [ROB_W-1:0] rob;
  } rs_entry_t;
  typedef struct packed {
    logic valid;
    logic [ROB_W-1:0] rob;
    logic [31:0] val;
  } cdb_t;
  typedef struct packed {
    logic busy;
    logic [ROB_W-1:0] q;
    logic [31:0] v;
  } operand_t;
  // A pending operand whose tag matches either broadcast takes its value and stops waiting.
  function automatic operand_t snoop(operand_t o, cdb_t a, cdb_t l);
    operand_t r;
    r = o;
    if (o.busy && a.valid && a.rob == o.q) begin
      r.busy = 1'b0;
      r.v = a.val;
    end else if (o.busy && l.valid && l.rob == o.q) begin
      r.busy = 1'b0;
      r.v = l.val;
    end
    return r;
  endfunction
endpackage

// File: rtl/alu_reservation_station_pick.sv
// rs_pick_lowest: finds the lowest set bit of req
//   req   in  N      request vector
//   found out 1      any bit set
//   idx   out W      index of the lowest set bit (0 when none)
module rs_pick_lowest #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);
  always_comb begin
    found = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/alu_reservation_station.sv
// alu_reservation_station: holds ALU/branch ops, resolves operands from CDB snoops, dispatches one ready op per cycle
//   clk_in, rst_in (sync, active-low), rdy_in (0 freezes all state), clear_in (flush)
//   issue_*       decoded op with operand values or pending ROB tags; rs_full flags no free entry
//   alu_cdb_*, lsb_cdb_*  result broadcasts snooped by pending operands
//   alu_*         registered dispatch to the ALU; alu_flag marks a valid op
module alu_reservation_station
  import alu_reservation_station_pkg::*;
#(
  parameter int RS_SIZE = alu_reservation_station_pkg::RS_SIZE,
  parameter int RS_W = alu_reservation_station_pkg::RS_W
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             issue_valid,
  input  logic [5:0]       issue_op,
  input  logic [31:0]      issue_vj,
  input  logic             issue_qj_busy,
  input  logic [ROB_W-1:0] issue_qj,
  input  logic [31:0]      issue_vk,
  input  logic             issue_qk_busy,
  input  logic [ROB_W-1:0] issue_qk,
  input  logic [ROB_W-1:0] issue_rob,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [ROB_W-1:0] alu_cdb_rob,
  input  logic [31:0]      alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [ROB_W-1:0] lsb_cdb_rob,
  input  logic [31:0]      lsb_cdb_val,
  output logic [31:0]      alu_val1,
  output logic [31:0]      alu_val2,
  output logic             alu_flag,
  output logic [5:0]       alu_opcode,
  output logic [ROB_W-1:0] alu_rob
);
  rs_entry_t ent [RS_SIZE];
  rs_entry_t ent_n [RS_SIZE];
  rs_entry_t issue_ent;
  rs_entry_t d;
  logic [RS_SIZE-1:0] free_vec, ready_vec;
  logic free_found, ready_found, dispatch;
  logic [RS_W-1:0] free_idx, ready_idx;
  cdb_t a_cdb, l_cdb;
  operand_t oj, ok;
  assign a_cdb = '{valid: alu_cdb_valid, rob: alu_cdb_rob, val: alu_cdb_val};
  assign l_cdb = '{valid: lsb_cdb_valid, rob: lsb_cdb_rob, val: lsb_cdb_val};
  always_comb begin
    free_vec = '0;
    ready_vec = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      free_vec[i] = !ent[i].busy;
      ready_vec[i] = ent[i].busy && !ent[i].qj_busy && !ent[i].qk_busy;
    end
  end
  rs_pick_lowest #(.N(RS_SIZE), .W(RS_W)) u_free (.req(free_vec), .found(free_found), .idx(free_idx));
  rs_pick_lowest #(.N(RS_SIZE), .W(RS_W)) u_ready (.req(ready_vec), .found(ready_found), .idx(ready_idx));
  assign rs_full = !free_found;
  assign d = ent[ready_idx];
  assign dispatch = ready_found && !clear_in;
  // Issuing operands snoop the same-cycle broadcasts so they never miss a result.
  assign oj = snoop('{busy: issue_qj_busy, q: issue_qj, v: issue_vj}, a_cdb, l_cdb);
  assign ok = snoop('{busy: issue_qk_busy, q: issue_qk, v: issue_vk}, a_cdb, l_cdb);
  assign issue_ent = '{busy: 1'b1, op: issue_op, vj: oj.v, vk: ok.v, qj_busy: oj.busy, qj: issue_qj,
                       qk_busy: ok.busy, qk: issue_qk, rob: issue_rob};
  // Issue targets a slot free in the registered state, so it never collides with the slot being dispatched.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      operand_t sj, sk;
      sj = snoop('{busy: ent[i].busy && ent[i].qj_busy, q: ent[i].qj, v: ent[i].vj}, a_cdb, l_cdb);
      sk = snoop('{busy: ent[i].busy && ent[i].qk_busy, q: ent[i].qk, v: ent[i].vk}, a_cdb, l_cdb);
      ent_n[i] = ent[i];
      ent_n[i].qj_busy = ent[i].qj_busy && sj.busy;
      ent_n[i].vj = sj.v;
      ent_n[i].qk_busy = ent[i].qk_busy && sk.busy;
      ent_n[i].vk = sk.v;
    end
    if (ready_found) ent_n[ready_idx].busy = 1'b0;
    if (issue_valid && free_found) ent_n[free_idx] = issue_ent;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
      alu_flag <= 1'b0;
      alu_val1 <= NULL32;
      alu_val2 <= NULL32;
      alu_opcode <= '0;
      alu_rob <= '0;
    end else if (rdy_in) begin
      for (int i = 0; i < RS_SIZE; i++) ent[i] <= clear_in ? '0 : ent_n[i];
      alu_flag <= dispatch;
      alu_val1 <= dispatch ? d.vj : NULL32;
      alu_val2 <= dispatch ? d.vk : NULL32;
      alu_opcode <= dispatch ? d.op : '0;
      alu_rob <= dispatch ? d.rob : '0;
    end
  end
endmodule

// File: tb/tb_alu_reservation_station.sv
// tb_alu_reservation_station: directed vectors and corner-case sequences for alu_reservation_station
module tb_alu_reservation_station;
  import alu_reservation_station_pkg::*;
  logic clk_in = 0, rst_in = 0, rdy_in = 1, clear_in = 0;
  logic issue_valid = 0, issue_qj_busy = 0, issue_qk_busy = 0;
  logic [5:0] issue_op = 0;
  logic [31:0] issue_vj = 0, issue_vk = 0;
  logic [3:0] issue_qj = 0, issue_qk = 0, issue_rob = 0;
  logic alu_cdb_valid = 0, lsb_cdb_valid = 0;
  logic [3:0] alu_cdb_rob = 0, lsb_cdb_rob = 0;
  logic [31:0] alu_cdb_val = 0, lsb_cdb_val = 0;
  logic rs_full, alu_flag;
  logic [31:0] alu_val1, alu_val2;
  logic [5:0] alu_opcode;
  logic [3:0] alu_rob;
  int n_chk = 0, n_fail = 0;
  alu_reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_vj(issue_vj), .issue_qj_busy(issue_qj_busy),
    .issue_qj(issue_qj), .issue_vk(issue_vk), .issue_qk_busy(issue_qk_busy), .issue_qk(issue_qk),
    .issue_rob(issue_rob), .rs_full(rs_full),
    .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob(alu_cdb_rob), .alu_cdb_val(alu_cdb_val),
    .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob(lsb_cdb_rob), .lsb_cdb_val(lsb_cdb_val),
    .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_flag(alu_flag), .alu_opcode(alu_opcode), .alu_rob(alu_rob)
  );
  always #5 clk_in = ~clk_in;
  typedef struct {
    logic iv; logic [5:0] op; logic [31:0] vj; logic qjb; logic [3:0] qj;
    logic [31:0] vk; logic qkb; logic [3:0] qk; logic [3:0] rob;
    logic acv; logic [3:0] arob; logic [31:0] aval;
    logic lcv; logic [3:0] lrob; logic [31:0] lval;
    logic ef; logic [31:0] ev1; logic [31:0] ev2; logic [5:0] eop; logic [3:0] erob;
  } vec_t;
  vec_t vq[$];
  function automatic vec_t mk(logic iv, logic [5:0] op, logic [31:0] vj, logic qjb, logic [3:0] qj,
                              logic [31:0] vk, logic qkb, logic [3:0] qk, logic [3:0] rob,
                              logic acv, logic [3:0] arob, logic [31:0] aval,
                              logic lcv, logic [3:0] lrob, logic [31:0] lval,
                              logic ef, logic [31:0] ev1, logic [31:0] ev2, logic [5:0] eop, logic [3:0] erob);
    vec_t v;
    v = '{iv, op, vj, qjb, qj, vk, qkb, qk, rob, acv, arob, aval, lcv, lrob, lval, ef, ev1, ev2, eop, erob};
    return v;
  endfunction
  function automatic vec_t idle(logic ef, logic [31:0] ev1, logic [31:0] ev2, logic [5:0] eop, logic [3:0] erob);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ef, ev1, ev2, eop, erob);
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic chk_out(string n, logic ef, logic [31:0] ev1, logic [31:0] ev2, logic [5:0] eop, logic [3:0] erob);
    chk({n, ".flag"}, 32'(alu_flag), 32'(ef));
    chk({n, ".val1"}, alu_val1, ev1);
    chk({n, ".val2"}, alu_val2, ev2);
    chk({n, ".opcode"}, 32'(alu_opcode), 32'(eop));
    chk({n, ".rob"}, 32'(alu_rob), 32'(erob));
  endtask
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask
  task automatic drive(vec_t v);
    issue_valid = v.iv; issue_op = v.op; issue_vj = v.vj; issue_qj_busy = v.qjb; issue_qj = v.qj;
    issue_vk = v.vk; issue_qk_busy = v.qkb; issue_qk = v.qk; issue_rob = v.rob;
    alu_cdb_valid = v.acv; alu_cdb_rob = v.arob; alu_cdb_val = v.aval;
    lsb_cdb_valid = v.lcv; lsb_cdb_rob = v.lrob; lsb_cdb_val = v.lval;
  endtask
  task automatic issue(logic [5:0] op, logic [31:0] vj, logic qjb, logic [3:0] qj, logic [31:0] vk, logic [3:0] rob);
    drive(mk(1, op, vj, qjb, qj, vk, 0, 0, rob, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask
  task automatic quiet();
    drive(idle(0, 0, 0, 0, 0));
  endtask
  initial begin
    // ready ADD dispatches one edge after being written, then the outputs return to zero
    vq.push_back(mk(1, OP_ADD, 5, 0, 0, 7, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(idle(1, 5, 7, OP_ADD, 3));
    vq.push_back(idle(0, 0, 0, 0, 0));
    // BEQ waiting on tag 2, woken by the ALU broadcast
    vq.push_back(mk(1, OP_BEQ, 0, 1, 2, 32'h10, 0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(idle(1, 32'h10, 32'h10, OP_BEQ, 4));
    // SUB whose qk is bypassed from a same-cycle load broadcast
    vq.push_back(mk(1, OP_SUB, 20, 0, 0, 0, 1, 5, 6, 0, 0, 0, 1, 5, 9, 0, 0, 0, 0, 0));
    vq.push_back(idle(1, 20, 9, OP_SUB, 6));
    // two pending ops woken together; third op issued during the first dispatch lands behind them
    vq.push_back(mk(1, OP_AND, 1, 1, 8, 2, 0, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, OP_OR, 0, 1, 10, 3, 0, 0, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 32'h11, 1, 10, 32'h22, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, OP_XOR, 32'h33, 0, 0, 32'h44, 0, 0, 11, 0, 0, 0, 0, 0, 0, 1, 32'h11, 2, OP_AND, 9));
    vq.push_back(idle(1, 32'h22, 3, OP_OR, 10));
    vq.push_back(idle(1, 32'h33, 32'h44, OP_XOR, 11));
    vq.push_back(idle(0, 0, 0, 0, 0));
    // qj bypassed from a same-cycle ALU broadcast
    vq.push_back(mk(1, OP_ADD, 0, 1, 12, 1, 0, 0, 12, 1, 12, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(idle(1, 32'h55, 1, OP_ADD, 12));
    // a non-matching broadcast must not wake the entry
    vq.push_back(mk(1, OP_SLT, 0, 1, 13, 4, 0, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 14, 9, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(idle(0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 13, 32'h66, 0, 0, 0, 0, 0));
    vq.push_back(idle(1, 32'h66, 4, OP_SLT, 13));
    vq.push_back(idle(0, 0, 0, 0, 0));
    rst_in = 0;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.full", 32'(rs_full), 0);
    rst_in = 1;
    foreach (vq[i]) begin
      drive(vq[i]);
      step();
      chk_out($sformatf("vec%0d", i), vq[i].ef, vq[i].ev1, vq[i].ev2, vq[i].eop, vq[i].erob);
      chk($sformatf("vec%0d.full", i), 32'(rs_full), 0);
    end
    // fill all 16 entries with ops waiting on tag 15
    for (int i = 0; i < 16; i++) begin
      issue(OP_ADD, 0, 1, 15, 32'(i), 4'(i));
      step();
      chk($sformatf("fill%0d.full", i), 32'(rs_full), (i == 15) ? 1 : 0);
      chk($sformatf("fill%0d.flag", i), 32'(alu_flag), 0);
    end
    issue(OP_XOR, 32'hAA, 0, 0, 1, 1);
    step();
    chk("drop.flag", 32'(alu_flag), 0);
    chk("drop.full", 32'(rs_full), 1);
    quiet();
    step();
    chk("drop2.flag", 32'(alu_flag), 0);
    clear_in = 1;
    alu_cdb_valid = 1; alu_cdb_rob = 15; alu_cdb_val = 32'h77;
    step();
    chk("clear.full", 32'(rs_full), 0);
    chk("clear.flag", 32'(alu_flag), 0);
    clear_in = 0;
    step();
    chk("clear2.flag", 32'(alu_flag), 0);
    quiet();
    step();
    chk("clear3.flag", 32'(alu_flag), 0);
    // stall with a dispatch on the outputs and a second ready op queued
    issue(OP_ADD, 1, 0, 0, 2, 5);
    step();
    chk("stall0.flag", 32'(alu_flag), 0);
    issue(OP_SUB, 3, 0, 0, 4, 6);
    step();
    chk_out("stall1", 1, 1, 2, OP_ADD, 5);
    rdy_in = 0;
    issue(OP_OR, 7, 0, 0, 8, 7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out($sformatf("hold%0d", i), 1, 1, 2, OP_ADD, 5);
    end
    rdy_in = 1;
    quiet();
    step();
    chk_out("resume", 1, 3, 4, OP_SUB, 6);
    step();
    chk_out("resume2", 0, 0, 0, 0, 0);
    // reset in the middle of operation discards both entries
    issue(OP_ADD, 0, 1, 3, 1, 2);
    step();
    issue(OP_AND, 9, 0, 0, 9, 4);
    step();
    quiet();
    rst_in = 0;
    step();
    chk_out("midrst", 0, 0, 0, 0, 0);
    chk("midrst.full", 32'(rs_full), 0);
    rst_in = 1;
    alu_cdb_valid = 1; alu_cdb_rob = 3; alu_cdb_val = 1;
    step();
    chk("midrst2.flag", 32'(alu_flag), 0);
    quiet();
    step();
    chk("midrst3.flag", 32'(alu_flag), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
